// File: rtl/gray_conv_arbiter_if.sv
// Request/result bundle between the requesters/consumer and the shared Gray converter.
interface gray_conv_arbiter_if #(
  parameter int unsigned W    = 4,
  parameter int unsigned NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] bin_in;
  logic [NREQ-1:0]   grant;
  logic [W-1:0]      gray_out;
  logic [2:0]        out_id;
  logic              out_valid;
  logic              out_ready;
  logic              busy;

  modport master (
    output req, bin_in, out_ready,
    input  grant, gray_out, out_id, out_valid, busy
  );

  modport slave (
    input  req, bin_in, out_ready,
    output grant, gray_out, out_id, out_valid, busy
  );
endinterface

// File: rtl/gray_conv_arbiter.sv
// One binary-to-Gray converter shared by NREQ requesters under round-robin arbitration;
// each accepted request yields one held result that the consumer must acknowledge.
module gray_conv_arbiter #(
  parameter int unsigned W    = 4,
  parameter int unsigned NREQ = 4
) (
  input  logic               clk,
  input  logic               rst,
  gray_conv_arbiter_if.slave bus
);

  localparam int unsigned IDW = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OUT  = 1'b1
  } state_t;

  state_t           state_q;
  logic [IDW-1:0]   ptr_q;
  logic [NREQ-1:0]  grant_q;
  logic [W-1:0]     gray_q;
  logic [IDW-1:0]   id_q;
  logic             valid_q;
  logic             busy_q;

  logic [IDW-1:0]   win_hi_c;
  logic [IDW-1:0]   win_lo_c;
  logic             found_hi_c;
  logic [IDW-1:0]   win_c;
  logic [W-1:0]     sel_bin_c;
  logic [W-1:0]     sel_gray_c;
  logic [NREQ-1:0]  win_onehot_c;

  // Round-robin pick: lowest requester above ptr, else lowest overall (wrap).
  always_comb begin
    win_hi_c   = '0;
    win_lo_c   = '0;
    found_hi_c = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        win_lo_c = IDW'(i);
        if (IDW'(i) > ptr_q) begin
          win_hi_c   = IDW'(i);
          found_hi_c = 1'b1;
        end
      end
    end
    win_c = found_hi_c ? win_hi_c : win_lo_c;
  end

  // Operand mux and conversion for the selected requester.
  always_comb begin
    sel_bin_c = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDW'(i) == win_c) begin
        sel_bin_c = bus.bin_in[i*W +: W];
      end
    end
    sel_gray_c   = sel_bin_c ^ (sel_bin_c >> 1);
    win_onehot_c = NREQ'(1) << win_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= IDW'(NREQ - 1);
      grant_q <= '0;
      gray_q  <= '0;
      id_q    <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      grant_q <= '0;
      case (state_q)
        IDLE: begin
          if (|bus.req) begin
            grant_q <= win_onehot_c;
            gray_q  <= sel_gray_c;
            id_q    <= win_c;
            ptr_q   <= win_c;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= OUT;
          end
        end
        OUT: begin
          // Result is held until acknowledged; no arbitration in the release edge.
          if (bus.out_ready) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.grant     = grant_q;
  assign bus.gray_out  = gray_q;
  assign bus.out_id    = id_q;
  assign bus.out_valid = valid_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Directed bench for gray_conv_arbiter: transaction-level model checked every cycle,
// plus hand-computed expectations at key points.
module tb_gray_conv_arbiter;

  localparam int W = 4;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  gray_conv_arbiter_if #(.W(W), .NREQ(N)) bus ();

  gray_conv_arbiter #(.W(W), .NREQ(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: a result slot that is either empty or holds one pending conversion.
  int              m_last;
  logic            m_pending;
  logic [N-1:0]    m_grant;
  logic [W-1:0]    m_gray;
  logic [2:0]      m_id;

  function automatic int rr_pick(input int last, input logic [N-1:0] r);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (last + k) % N;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_last    = N - 1;
      m_pending = 1'b0;
      m_grant   = '0;
      m_gray    = '0;
      m_id      = '0;
    end else begin
      m_grant = '0;
      if (m_pending) begin
        if (bus.out_ready) m_pending = 1'b0;
      end else begin
        int w;
        w = rr_pick(m_last, bus.req);
        if (w >= 0) begin
          logic [W-1:0] b;
          b         = bus.bin_in[w*W +: W];
          m_gray    = b ^ (b >> 1);
          m_id      = 3'(w);
          m_grant   = '0;
          m_grant[w] = 1'b1;
          m_last    = w;
          m_pending = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("m_grant", bus.grant, m_grant);
    chk("m_valid", bus.out_valid, m_pending);
    chk("m_busy", bus.busy, m_pending);
    if (m_pending) begin
      chk("m_gray", bus.gray_out, m_gray);
      chk("m_id", bus.out_id, m_id);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy === 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("idle_timeout", bus.busy, 0);
  endtask

  logic [3:0] exp_g  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [2:0] exp_id [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};

  initial begin
    bus.req       = '0;
    bus.bin_in    = '0;
    bus.out_ready = 1'b0;
    #1 rst = 1'b1;
    tick();
    chk("rst_grant", bus.grant, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_gray", bus.gray_out, 0);
    chk("rst_id", bus.out_id, 0);
    chk("rst_busy", bus.busy, 0);

    // Full contention with consumer always ready: rotating grants every other cycle.
    bus.req       = 4'b1111;
    bus.out_ready = 1'b1;
    bus.bin_in    = 16'h4321;
    rst           = 1'b0;
    for (int k = 0; k < 9; k++) begin
      tick();
      if (k % 2 == 0) begin
        chk("rr_grant", bus.grant, exp_g[k/2]);
        chk("rr_id", bus.out_id, exp_id[k/2]);
      end else begin
        chk("rr_gap", bus.out_valid, 0);
      end
    end
    bus.req = '0;
    wait_idle();

    // Single requester 2 with operand 1011.
    bus.req    = 4'b0100;
    bus.bin_in = 16'h0B00;
    tick();
    chk("b_grant", bus.grant, 4'b0100);
    chk("b_gray", bus.gray_out, 4'b1110);
    chk("b_id", bus.out_id, 2);
    chk("b_valid", bus.out_valid, 1);
    bus.req = '0;
    tick();
    chk("b_grant_pulse", bus.grant, 0);
    chk("b_valid_drop", bus.out_valid, 0);

    // Every 4-bit operand on requester 0.
    for (int b = 0; b < 16; b++) begin
      logic [3:0] bv;
      bv         = 4'(b);
      bus.bin_in = {12'h000, bv};
      bus.req    = 4'b0001;
      tick();
      chk("ex_grant", bus.grant, 4'b0001);
      chk("ex_gray", bus.gray_out, bv ^ (bv >> 1));
      if (b == 15) chk("ex_gray_f", bus.gray_out, 4'b1000);
      if (b == 7)  chk("ex_gray_7", bus.gray_out, 4'b0100);
      bus.req = '0;
      tick();
    end

    // Backpressure: result holds while operands and requests change underneath.
    bus.out_ready = 1'b0;
    bus.req       = 4'b0010;
    bus.bin_in    = 16'h0060;
    tick();
    chk("bp_grant", bus.grant, 4'b0010);
    chk("bp_valid", bus.out_valid, 1);
    bus.req    = 4'b1111;
    bus.bin_in = 16'hFFFF;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_hold_grant", bus.grant, 0);
      chk("bp_hold_gray", bus.gray_out, 4'b0101);
      chk("bp_hold_id", bus.out_id, 1);
      chk("bp_hold_busy", bus.busy, 1);
      chk("bp_hold_valid", bus.out_valid, 1);
    end
    bus.out_ready = 1'b1;
    tick();
    chk("bp_release_valid", bus.out_valid, 0);
    chk("bp_release_grant", bus.grant, 0);
    bus.req = '0;

    // Asynchronous reset while a result is pending.
    bus.out_ready = 1'b0;
    bus.req       = 4'b1100;
    tick();
    chk("ar_grant", bus.grant, 4'b0100);
    chk("ar_valid", bus.out_valid, 1);
    #1 rst = 1'b1;
    #1;
    chk("ar_valid0", bus.out_valid, 0);
    chk("ar_grant0", bus.grant, 0);
    chk("ar_gray0", bus.gray_out, 0);
    chk("ar_id0", bus.out_id, 0);
    chk("ar_busy0", bus.busy, 0);
    bus.req = 4'b0101;
    tick();
    rst = 1'b0;
    tick();
    chk("ar_first_grant", bus.grant, 4'b0001);
    chk("ar_first_id", bus.out_id, 0);

    // Wrap-around from requester 3 back to 0.
    bus.out_ready = 1'b1;
    bus.req       = 4'b1000;
    tick();
    chk("wr_idle", bus.grant, 0);
    tick();
    chk("wr_g3", bus.grant, 4'b1000);
    bus.req = 4'b1001;
    tick();
    chk("wr_gap", bus.grant, 0);
    tick();
    chk("wr_g0", bus.grant, 4'b0001);
    tick();
    tick();
    chk("wr_g3b", bus.grant, 4'b1000);

    bus.req = '0;
    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
